debounce_events: RTL and testbench

Multi-channel switch conditioner and next generation of the single-sided debounce filter. Each channel is synchronised, optionally inverted, and filtered symmetrically: both press and release need N consecutive agreeing samples. Each channel emits a filtered level, one-cycle rise/fall event pulses, and long-press hold pulses with optional auto-repeat. The block sits between board pins and user logic such as menu FSMs and counters.

---
 rtl/debounce_pkg.sv | 17 +
 rtl/debounce_channel.sv | 137 +++++++++++++
 rtl/debounce_events.sv | 79 +++++++
 tb/tb_debounce_events.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the debounce_events switch conditioner.
package debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        HELD     = 2'd2
    } hold_state_t;

    // Bits needed to hold the larger of two counts without wrapping.
    function automatic int clog2_max(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: synchroniser, symmetric disagree filter, edge events
// and long-press / auto-repeat hold FSM.
//
// state    | meaning
// RELEASED | filtered level is 0, no hold timing running
// PRESSED  | level is 1, counting ticks towards the first hold pulse
// HELD     | first hold pulse issued, counting repeat intervals (if enabled)
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   FILTER_COUNT   = 3,
    parameter int   SYNC_DEPTH     = 2,
    parameter logic INVERT         = 1'b0,
    parameter int   HOLD_SAMPLES   = 500,
    parameter int   REPEAT_SAMPLES = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic sample_tick,
    input  logic async_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic hold_pulse
);
    localparam int FILT_W = $clog2(FILTER_COUNT + 1);
    localparam int HOLD_W = clog2_max(HOLD_SAMPLES, REPEAT_SAMPLES);
    localparam logic [FILT_W-1:0] FILT_LAST   = FILT_W'(FILTER_COUNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_SAMPLES);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_SAMPLES);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic [FILT_W-1:0]     filt_cnt_q, filt_cnt_d;
    logic                  level_q, level_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  hold_q, hold_d;
    hold_state_t           state_q, state_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d, hold_cnt_inc;
    logic                  sample;

    // Synchroniser resets to the pin's idle value so no false press follows reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_DEPTH{INVERT}};
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], async_in};
        end
    end

    assign sample       = sync_q[SYNC_DEPTH-1] ^ INVERT;
    assign hold_cnt_inc = hold_cnt_q + HOLD_W'(1);

    // Disagree filter: level flips only after FILTER_COUNT consecutive disagreeing ticks.
    always_comb begin
        filt_cnt_d = filt_cnt_q;
        level_d    = level_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        if (sample_tick) begin
            if (sample == level_q) begin
                filt_cnt_d = '0;
            end else if (filt_cnt_q == FILT_LAST) begin
                filt_cnt_d = '0;
                level_d    = ~level_q;
                rise_d     = ~level_q;
                fall_d     = level_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FILT_W'(1);
            end
        end
    end

    // Hold FSM next state; a fall wins over any coincident hold match.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        hold_d     = 1'b0;
        if (fall_d) begin
            state_d    = RELEASED;
            hold_cnt_d = '0;
        end else if (rise_d) begin
            state_d    = PRESSED;
            hold_cnt_d = '0;
        end else if (sample_tick) begin
            unique case (state_q)
                PRESSED: begin
                    if (hold_cnt_inc == HOLD_LAST) begin
                        hold_d     = 1'b1;
                        state_d    = HELD;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_inc;
                    end
                end
                HELD: begin
                    if (REPEAT_SAMPLES > 0) begin
                        if (hold_cnt_inc == REPEAT_LAST) begin
                            hold_d     = 1'b1;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_inc;
                        end
                    end
                end
                default: hold_cnt_d = '0;
            endcase
        end
    end

    // Filter, event and hold registers; pulses land with the new level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filt_cnt_q <= '0;
            level_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            hold_q     <= 1'b0;
            state_q    <= RELEASED;
            hold_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            hold_q     <= hold_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign hold_pulse = hold_q;

endmodule

// File: rtl/debounce_events.sv
// Multi-channel switch conditioner: shared sample prescaler plus one
// independent debounce_channel per pin.
module debounce_events
    import debounce_pkg::*;
#(
    parameter longint                CLOCK_HZ       = 12_000_000,
    parameter longint                SAMPLE_HZ      = 1000,
    parameter int                    FILTER_COUNT   = 3,
    parameter int                    PORT_BITS      = 1,
    parameter int                    SYNC_DEPTH     = 2,
    parameter logic [PORT_BITS-1:0]  INVERT_MASK    = '0,
    parameter int                    HOLD_SAMPLES   = 500,
    parameter int                    REPEAT_SAMPLES = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [PORT_BITS-1:0] async_in,
    output logic [PORT_BITS-1:0] level_out,
    output logic [PORT_BITS-1:0] rise_pulse,
    output logic [PORT_BITS-1:0] fall_pulse,
    output logic [PORT_BITS-1:0] hold_pulse,
    output logic                 sample_tick
);
    localparam longint DIV_L = CLOCK_HZ / SAMPLE_HZ;
    localparam int     DIV   = int'(DIV_L);
    localparam int     PRE_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("debounce_events: CLOCK_HZ/SAMPLE_HZ must be >= 2");
    end
    if (FILTER_COUNT < 1) begin : g_bad_filter
        $error("debounce_events: FILTER_COUNT must be >= 1");
    end
    if (HOLD_SAMPLES < 1) begin : g_bad_hold
        $error("debounce_events: HOLD_SAMPLES must be >= 1");
    end
    if (SYNC_DEPTH < 2) begin : g_bad_sync
        $error("debounce_events: SYNC_DEPTH must be >= 2");
    end

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

    // Prescaler wraps at DIV-1; the tick is decoded from the terminal count.
    always_comb begin
        pre_cnt_d = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + PRE_W'(1);
    end

    // Prescaler register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

    assign sample_tick = (pre_cnt_q == PRE_LAST);

    for (genvar i = 0; i < PORT_BITS; i++) begin : g_chan
        debounce_channel #(
            .FILTER_COUNT   (FILTER_COUNT),
            .SYNC_DEPTH     (SYNC_DEPTH),
            .INVERT         (INVERT_MASK[i]),
            .HOLD_SAMPLES   (HOLD_SAMPLES),
            .REPEAT_SAMPLES (REPEAT_SAMPLES)
        ) u_chan (
            .clock       (clock),
            .reset       (reset),
            .sample_tick (sample_tick),
            .async_in    (async_in[i]),
            .level_out   (level_out[i]),
            .rise_pulse  (rise_pulse[i]),
            .fall_pulse  (fall_pulse[i]),
            .hold_pulse  (hold_pulse[i])
        );
    end

endmodule

// File: tb/tb_debounce_events.sv
// Bench for debounce_events: expected event records are queued when pin
// stimulus is applied and popped whenever any pulse output fires.
module tb_debounce_events;
    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic [1:0] async_in = 2'b10;
    logic [1:0] level_out, rise_pulse, fall_pulse, hold_pulse;
    logic       sample_tick;

    int          n_checks = 0;
    int          n_errors = 0;
    int          tick_cnt = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_got;

    always #5 clock = ~clock;

    debounce_events #(
        .CLOCK_HZ       (100),
        .SAMPLE_HZ      (10),
        .FILTER_COUNT   (3),
        .PORT_BITS      (2),
        .SYNC_DEPTH     (2),
        .INVERT_MASK    (2'b10),
        .HOLD_SAMPLES   (5),
        .REPEAT_SAMPLES (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .async_in    (async_in),
        .level_out   (level_out),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .hold_pulse  (hold_pulse),
        .sample_tick (sample_tick)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event record: tick number of the producing sample edge, then pulses and level.
    function automatic logic [63:0] ev(input int t, input logic [1:0] r, input logic [1:0] f,
                                       input logic [1:0] h, input logic [1:0] l);
        return {24'd0, 32'(t), r, f, h, l};
    endfunction

    // Counts sample edges since reset; after tick edge t the value is t.
    always @(posedge clock or posedge reset) begin
        if (reset) tick_cnt <= 0;
        else if (sample_tick) tick_cnt <= tick_cnt + 1;
    end

    // Any pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (!reset && (|{rise_pulse, fall_pulse, hold_pulse})) begin
            check("rise_fall_exclusive", 64'(rise_pulse & fall_pulse), 64'd0);
            mon_got = ev(tick_cnt, rise_pulse, fall_pulse, hold_pulse, level_out);
            if (exp_q.size() == 0) check("spurious_event", mon_got, 64'd0);
            else check("event", mon_got, exp_q.pop_front());
        end
    end

    task automatic next_tick();
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (sample_tick) return;
        end
        check("tick_timeout", 64'd0, 64'd1);
    endtask

    // Drives pins just before a tick edge; returns the first tick that samples them.
    task automatic apply(input logic [1:0] pins, output int seen);
        next_tick();
        async_in = pins;
        seen = tick_cnt + 2;
    endtask

    initial begin
        int          s, r, seen, first, last, n_ticks, bad_gaps;
        logic [7:0]  idle_or;

        // 1: reset and idle
        repeat (3) @(negedge clock);
        check("reset_outputs", 64'({level_out, rise_pulse, fall_pulse, hold_pulse, sample_tick}), 64'd0);
        reset = 1'b0;
        first = -1; last = -1; n_ticks = 0; bad_gaps = 0; idle_or = '0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clock);
            idle_or |= {level_out, rise_pulse, fall_pulse, hold_pulse};
            if (sample_tick) begin
                if (first < 0) first = i;
                else if (i - last != 10) bad_gaps++;
                last = i;
                n_ticks++;
            end
        end
        check("idle_outputs", 64'(idle_or), 64'd0);
        // tick is high after the 9th edge and consumed by the 10th
        check("first_tick", 64'(first), 64'd9);
        check("tick_gaps", 64'(bad_gaps), 64'd0);
        check("tick_total", 64'(n_ticks), 64'd20);

        // 2: glitch of two samples
        apply(2'b11, seen);
        apply(2'b11, seen);
        repeat (4) apply(2'b10, seen);
        check("glitch_level", 64'(level_out), 64'd0);

        // 3 + 4: clean press, long press with repeat, chattering release
        apply(2'b11, s);
        r = s + 2;
        exp_q.push_back(ev(r, 2'b01, 2'b00, 2'b00, 2'b01));
        for (int k = 5; k <= 15; k += 2) exp_q.push_back(ev(r + k, 2'b00, 2'b00, 2'b01, 2'b01));
        exp_q.push_back(ev(r + 17, 2'b00, 2'b01, 2'b00, 2'b00));
        seen = s;
        for (int k = 0; k < 40 && seen < r + 12; k++) apply(2'b11, seen);
        check("press_level", 64'(level_out), 64'd1);
        apply(2'b10, seen);
        apply(2'b11, seen);
        repeat (3) apply(2'b10, seen);
        check("chatter_seen_tick", 64'(seen), 64'(r + 17));
        repeat (2) apply(2'b10, seen);
        check("release_level", 64'(level_out), 64'd0);

        // 5: active-low ch1 alone, then both channels together
        apply(2'b00, s);
        exp_q.push_back(ev(s + 2, 2'b10, 2'b00, 2'b00, 2'b10));
        exp_q.push_back(ev(s + 5, 2'b00, 2'b10, 2'b00, 2'b00));
        repeat (2) apply(2'b00, seen);
        apply(2'b10, seen);
        apply(2'b10, seen);
        check("ch1_level", 64'(level_out), 64'd2);
        apply(2'b10, seen);

        apply(2'b01, s);
        exp_q.push_back(ev(s + 2, 2'b11, 2'b00, 2'b00, 2'b11));
        exp_q.push_back(ev(s + 5, 2'b00, 2'b11, 2'b00, 2'b00));
        repeat (2) apply(2'b01, seen);
        repeat (3) apply(2'b10, seen);

        // 6: async reset while HELD, then a fresh press timeline
        apply(2'b11, s);
        r = s + 2;
        exp_q.push_back(ev(r, 2'b01, 2'b00, 2'b00, 2'b01));
        exp_q.push_back(ev(r + 5, 2'b00, 2'b00, 2'b01, 2'b01));
        seen = s;
        for (int k = 0; k < 40 && seen < r + 7; k++) apply(2'b11, seen);
        check("queue_before_reset", 64'(exp_q.size()), 64'd0);
        check("held_level", 64'(level_out), 64'd1);
        #2 reset = 1'b1;
        #1 check("async_reset", 64'({level_out, rise_pulse, fall_pulse, hold_pulse, sample_tick}), 64'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        exp_q.push_back(ev(3, 2'b01, 2'b00, 2'b00, 2'b01));
        exp_q.push_back(ev(8, 2'b00, 2'b00, 2'b01, 2'b01));
        exp_q.push_back(ev(10, 2'b00, 2'b00, 2'b01, 2'b01));
        exp_q.push_back(ev(12, 2'b00, 2'b01, 2'b00, 2'b00));
        seen = 0;
        for (int k = 0; k < 40 && seen < 9; k++) apply(2'b11, seen);
        repeat (6) apply(2'b10, seen);
        check("final_level", 64'(level_out), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
